// File: rtl/ptt_sequencer.sv
// ptt_sequencer: TX/RX sequencer and PTT arbiter; define PTT_SEQ_TOT_EN for the transmit time-out.
module ptt_sequencer #(
    parameter int SWITCH_CYCLES  = 100_000,
    parameter int TXDELAY_CYCLES = 30_000_000,
    parameter int TAIL_CYCLES    = 5_000_000,
    parameter int TOT_CYCLES     = 2_000_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ptt_req,
    input  logic       pkt_req,
    input  logic       pkt_done,
    input  logic       mod_busy,
    output logic       rx_mute,
    output logic       rf_sw_tx,
    output logic       pa_en,
    output logic       pkt_grant,
    output logic       owner,
    output logic       tot_flag,
    output logic [2:0] state
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] KEYUP   = 3'd1;
    localparam logic [2:0] TXDELAY = 3'd2;
    localparam logic [2:0] TX      = 3'd3;
    localparam logic [2:0] TAIL    = 3'd4;
    localparam logic [2:0] KEYDOWN = 3'd5;
    localparam logic [2:0] LOCKOUT = 3'd6;
    localparam int MAX_A = SWITCH_CYCLES > TXDELAY_CYCLES ? SWITCH_CYCLES : TXDELAY_CYCLES;
    localparam int MAX_B = TAIL_CYCLES > TOT_CYCLES ? TAIL_CYCLES : TOT_CYCLES;
    localparam int TW = $clog2(MAX_A > MAX_B ? MAX_A : MAX_B) + 1;
    logic [2:0]    nxt;
    logic          own_nxt;
    logic          done;
    logic          expire;
    logic [TW-1:0] timer;
    logic [TW-1:0] load;
    always_comb begin
        nxt = state;
        own_nxt = owner;
        done = timer == '0;
        case (state)
            IDLE: begin
                nxt = (ptt_req || pkt_req) ? KEYUP : IDLE;
                own_nxt = (ptt_req || pkt_req) ? !ptt_req : owner;
            end
            KEYUP:   nxt = (!owner && !ptt_req) ? KEYDOWN : done ? TXDELAY : KEYUP;
            TXDELAY: nxt = (!owner && !ptt_req) ? KEYDOWN : done ? TX : TXDELAY;
            TX:      nxt = (owner ? pkt_done : !ptt_req) ? TAIL : TX;
            TAIL:    nxt = (done && !mod_busy) ? KEYDOWN : TAIL;
            KEYDOWN: nxt = done ? (tot_flag ? LOCKOUT : IDLE) : KEYDOWN;
            LOCKOUT: nxt = (!ptt_req && !pkt_req) ? IDLE : LOCKOUT;
            default: nxt = IDLE;
        endcase
        if (expire) nxt = TAIL;
    end
    // Each state's count is loaded as N-1 on entry so the state lasts exactly N cycles.
    assign load = (nxt == KEYUP || nxt == KEYDOWN) ? TW'(SWITCH_CYCLES - 1) :
                  nxt == TXDELAY ? TW'(TXDELAY_CYCLES - 1) :
                  nxt == TAIL ? TW'(TAIL_CYCLES - 1) : '0;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            owner <= 1'b0;
            timer <= '0;
            rx_mute <= 1'b0;
            rf_sw_tx <= 1'b0;
            pa_en <= 1'b0;
            pkt_grant <= 1'b0;
        end else begin
            state <= nxt;
            owner <= own_nxt;
            timer <= nxt != state ? load : done ? timer : timer - 1'b1;
            rx_mute <= nxt != IDLE && nxt != LOCKOUT;
            rf_sw_tx <= nxt inside {KEYUP, TXDELAY, TX, TAIL, KEYDOWN};
            pa_en <= nxt inside {TXDELAY, TX, TAIL};
            pkt_grant <= nxt == TX && own_nxt;
        end
    end
`ifdef PTT_SEQ_TOT_EN
    localparam int CW = $clog2(TOT_CYCLES) + 1;
    logic [CW-1:0] tot_cnt;
    logic          counting;
    assign counting = state inside {KEYUP, TXDELAY, TX};
    assign expire = counting && tot_cnt == CW'(TOT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tot_cnt <= '0;
            tot_flag <= 1'b0;
        end else begin
            tot_cnt <= counting ? tot_cnt + 1'b1 : '0;
            tot_flag <= expire || (tot_flag && !(state == LOCKOUT && nxt == IDLE));
        end
    end
`else
    assign expire = 1'b0;
    assign tot_flag = 1'b0;
`endif
endmodule

// File: tb/tb_ptt_sequencer.sv
// tb_ptt_sequencer: directed checks of ptt_sequencer with parameters 4/8/3/64.
module tb_ptt_sequencer;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ptt_req = 1'b0;
    logic       pkt_req = 1'b0;
    logic       pkt_done = 1'b0;
    logic       mod_busy = 1'b0;
    logic       rx_mute, rf_sw_tx, pa_en, pkt_grant, owner, tot_flag;
    logic [2:0] state;
    logic [8:0] outs;
    int         total = 0;
    int         bad = 0;

    ptt_sequencer #(
        .SWITCH_CYCLES(4), .TXDELAY_CYCLES(8), .TAIL_CYCLES(3), .TOT_CYCLES(64)
    ) dut (
        .clk(clk), .resetn(resetn), .ptt_req(ptt_req), .pkt_req(pkt_req),
        .pkt_done(pkt_done), .mod_busy(mod_busy), .rx_mute(rx_mute),
        .rf_sw_tx(rf_sw_tx), .pa_en(pa_en), .pkt_grant(pkt_grant),
        .owner(owner), .tot_flag(tot_flag), .state(state)
    );

    always #5 clk = ~clk;
    // {rx_mute, rf_sw_tx, pa_en, pkt_grant, owner, tot_flag, state}
    assign outs = {rx_mute, rf_sw_tx, pa_en, pkt_grant, owner, tot_flag, state};

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // IDLE view without owner, which is only meaningful while rx_mute is high
    function automatic logic [8:0] idle_view();
        return {1'b0, rx_mute, rf_sw_tx, pa_en, pkt_grant, tot_flag, state};
    endfunction

    initial begin
        step(2);
        chk("reset", outs, 9'b0_0000_0000);
        resetn = 1'b1;
        step(1);
        chk("idle_after_reset", outs, 9'b0_0000_0000);

        ptt_req = 1'b1;
        step(1);
        chk("man_keyup", outs, 9'b1100_00_001);
        step(3);
        chk("man_keyup_end", outs, 9'b1100_00_001);
        step(1);
        chk("man_txdelay", outs, 9'b1110_00_010);
        step(8);
        chk("man_tx", outs, 9'b1110_00_011);
        step(17);
        chk("man_tx_hold", outs, 9'b1110_00_011);
        ptt_req = 1'b0;
        step(1);
        chk("man_tail", outs, 9'b1110_00_100);
        step(2);
        chk("man_tail_end", outs, 9'b1110_00_100);
        step(1);
        chk("man_keydown", outs, 9'b1100_00_101);
        step(3);
        chk("man_keydown_end", outs, 9'b1100_00_101);
        step(1);
        chk("man_idle", idle_view(), 9'b0);

        pkt_req = 1'b1;
        step(1);
        chk("pkt_keyup", outs, 9'b1100_10_001);
        step(4);
        chk("pkt_txdelay", outs, 9'b1110_10_010);
        step(7);
        chk("pkt_txdelay_end", outs, 9'b1110_10_010);
        step(1);
        chk("pkt_grant", outs, 9'b1111_10_011);
        pkt_req = 1'b0;
        step(4);
        chk("pkt_grant_5th", outs, 9'b1111_10_011);
        pkt_done = 1'b1;
        mod_busy = 1'b1;
        step(1);
        pkt_done = 1'b0;
        chk("pkt_tail", outs, 9'b1110_10_100);
        step(3);
        chk("pkt_tail_busy", outs, 9'b1110_10_100);
        step(2);
        chk("pkt_tail_6th", outs, 9'b1110_10_100);
        mod_busy = 1'b0;
        step(1);
        chk("pkt_keydown", outs, 9'b1100_10_101);
        pkt_done = 1'b1;
        step(1);
        pkt_done = 1'b0;
        chk("pkt_done_ignored", outs, 9'b1100_10_101);
        step(3);
        chk("pkt_idle", idle_view(), 9'b0);

        ptt_req = 1'b1;
        pkt_req = 1'b1;
        step(1);
        chk("both_manual_wins", outs, 9'b1100_00_001);
        step(12);
        chk("both_tx_no_grant", outs, 9'b1110_00_011);
        ptt_req = 1'b0;
        step(1);
        chk("both_tail", outs, 9'b1110_00_100);
        step(3);
        chk("both_keydown", outs, 9'b1100_00_101);
        step(4);
        chk("both_idle", idle_view(), 9'b0);
        step(1);
        chk("both_pkt_keyup", outs, 9'b1100_10_001);
        step(12);
        chk("both_pkt_grant", outs, 9'b1111_10_011);
        pkt_req = 1'b0;
        pkt_done = 1'b1;
        step(1);
        pkt_done = 1'b0;
        chk("both_pkt_tail", outs, 9'b1110_10_100);
        step(7);
        chk("both_pkt_idle", idle_view(), 9'b0);

        ptt_req = 1'b1;
        step(2);
        chk("abort_keyup", outs, 9'b1100_00_001);
        ptt_req = 1'b0;
        step(1);
        chk("abort_keydown", outs, 9'b1100_00_101);
        step(3);
        chk("abort_keydown_end", outs, 9'b1100_00_101);
        step(1);
        chk("abort_idle", idle_view(), 9'b0);

        ptt_req = 1'b1;
        step(13);
        chk("rst_tx", outs, 9'b1110_00_011);
        resetn = 1'b0;
        step(1);
        chk("rst_mid_tx", outs, 9'b0);
        resetn = 1'b1;
        ptt_req = 1'b0;
        step(1);
        chk("rst_idle", outs, 9'b0);

`ifdef PTT_SEQ_TOT_EN
        ptt_req = 1'b1;
        step(1);
        chk("tot_keyup", outs, 9'b1100_00_001);
        step(63);
        chk("tot_tx_last", outs, 9'b1110_00_011);
        step(1);
        chk("tot_tail", outs, 9'b1110_01_100);
        step(3);
        chk("tot_keydown", outs, 9'b1100_01_101);
        step(4);
        chk("tot_lockout", outs, 9'b0000_01_110);
        step(10);
        chk("tot_lockout_hold", outs, 9'b0000_01_110);
        ptt_req = 1'b0;
        step(1);
        chk("tot_idle", outs, 9'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
